// File: rtl/frogger_pkg.sv
// Shared types and constants for the frog movement input path.
package frogger_pkg;

  typedef enum logic [2:0] {IDLE, ARM, HELD, RPT, REL} btn_state_t;

  localparam int NUM_KEYS = 4;
  localparam int KEY_R    = 0;
  localparam int KEY_L    = 1;
  localparam int KEY_D    = 2;
  localparam int KEY_U    = 3;

  // Width of a counter that must reach max(a,b,c)-1; never below one bit.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Button/round-event inputs and move-pulse outputs of the input stage.
interface move_input_ctrl_if;

  logic [frogger_pkg::NUM_KEYS-1:0] key_n;
  logic                             winResult;
  logic                             loseResult;
  logic                             L;
  logic                             R;
  logic                             U;
  logic                             D;
  logic                             busy;

  modport master (
    output key_n, winResult, loseResult,
    input  L, R, U, D, busy
  );

  modport slave (
    input  key_n, winResult, loseResult,
    output L, R, U, D, busy
  );

endinterface

// File: rtl/key_conditioner.sv
// One key: 2-flop sync, debounce, press-and-hold auto-repeat, registered pulse p.
module key_conditioner
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic force_rel,
  output logic p
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

  logic          s1, s2, btn_s;
  btn_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          p_nx;

  // Raw key is active-low; sync flops reset to "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
    end
  end

  assign btn_s = s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      p     <= p_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (force_rel) begin
      // Round end: a held key must be released and re-pressed to move again.
      state_nx = REL;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: if (btn_s) begin
          state_nx = ARM;
          cnt_nx   = '0;
        end
        ARM: begin
          if (!btn_s)               state_nx = IDLE;
          else if (cnt == DB_LAST) begin
            state_nx = HELD;
            cnt_nx   = '0;
          end else                  cnt_nx   = cnt + CW'(1);
        end
        HELD: begin
          if (!btn_s) begin
            state_nx = REL;
            cnt_nx   = '0;
          end else if (cnt == RD_LAST) begin
            state_nx = RPT;
            cnt_nx   = '0;
          end else cnt_nx = cnt + CW'(1);
        end
        RPT: begin
          if (!btn_s) begin
            state_nx = REL;
            cnt_nx   = '0;
          end else if (cnt == RR_LAST) cnt_nx = '0;
          else                         cnt_nx = cnt + CW'(1);
        end
        REL: begin
          if (btn_s)               cnt_nx = '0;
          else if (cnt == DB_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else                 cnt_nx = cnt + CW'(1);
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_comb begin
    p_nx = 1'b0;
    if (!force_rel && btn_s) begin
      case (state)
        ARM:     p_nx = (cnt == DB_LAST);
        HELD:    p_nx = (cnt == RD_LAST);
        RPT:     p_nx = (cnt == RR_LAST);
        default: p_nx = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Four key conditioners, drop-on-conflict exclusion, registered move pulses, round-end hold-off.
module move_input_ctrl
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int HOLDOFF         = 32
) (
  input  logic               clk,
  input  logic               reset,
  move_input_ctrl_if.slave   io
);

  localparam int HW = ($clog2(HOLDOFF + 1) < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic [NUM_KEYS-1:0] p;
  logic [NUM_KEYS-1:0] out_q;
  logic [HW-1:0]       hcnt;
  logic                round_end;
  logic                multi;
  logic                blocked;

  assign round_end = io.winResult | io.loseResult;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_key (
      .clk       (clk),
      .reset     (reset),
      .key_n     (io.key_n[g]),
      .force_rel (round_end),
      .p         (p[g])
    );
  end

  // More than one simultaneous pulse is ambiguous: drop it rather than pick one.
  assign multi   = |(p & (p - NUM_KEYS'(1)));
  assign blocked = round_end | (hcnt != '0) | multi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               hcnt <= '0;
    else if (round_end)      hcnt <= HW'(HOLDOFF);
    else if (hcnt != '0)     hcnt <= hcnt - HW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        out_q <= '0;
    else if (blocked) out_q <= '0;
    else              out_q <= p;
  end

  assign io.R    = out_q[KEY_R];
  assign io.L    = out_q[KEY_L];
  assign io.D    = out_q[KEY_D];
  assign io.U    = out_q[KEY_U];
  assign io.busy = (hcnt != '0);

endmodule

// File: tb/tb_move_input_ctrl.sv
// Randomised + directed bench; run-length reference model feeds a pulse scoreboard.
module tb_move_input_ctrl;
  import frogger_pkg::*;

  localparam int DB = 4;
  localparam int RD = 64;
  localparam int RR = 16;
  localparam int HO = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_input_ctrl_if io();

  move_input_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .HOLDOFF         (HO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } ev_t;

  ev_t  q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  // Reference model state: sync history, held-run length h, lock with zero-run z.
  bit [3:0] ms1, ms2, pm, np, om;
  bit       locked [4];
  int       z [4];
  int       h [4];
  int       hc;
  bit       exp_busy;
  bit       w, b;
  int       t;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      ms1 = '0; ms2 = '0; pm = '0; hc = 0; exp_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        locked[i] = 1'b0; z[i] = 0; h[i] = 0;
      end
    end else begin
      w  = io.winResult | io.loseResult;
      om = pm;
      if (w || hc != 0 || $countones(pm) > 1) om = '0;
      if (om != '0) q.push_back('{cyc, om});
      hc       = w ? HO : (hc > 0 ? hc - 1 : 0);
      exp_busy = (hc != 0);
      for (int i = 0; i < 4; i++) begin
        b     = ms2[i];
        np[i] = 1'b0;
        if (w) begin
          locked[i] = 1'b1; z[i] = 0; h[i] = 0;
        end else if (locked[i]) begin
          if (b) z[i] = 0;
          else begin
            z[i]++;
            if (z[i] == DB) locked[i] = 1'b0;
          end
        end else if (b) begin
          h[i]++;
          t     = h[i] - (DB + 1);
          np[i] = (t == 0) || (t >= RD && ((t - RD) % RR) == 0);
        end else begin
          // Released after having produced a pulse: needs a clean release first.
          if (h[i] >= DB + 1) begin
            locked[i] = 1'b1; z[i] = 0;
          end
          h[i] = 0;
        end
      end
      ms2 = ms1;
      ms1 = ~io.key_n;
      pm  = np;
    end
  end

  logic [3:0] m;
  ev_t        e;

  always @(negedge clk) begin
    if (!reset) begin
      total_cnt++;
      if (io.busy === exp_busy) pass_cnt++;
      else $display("FAIL busy cyc=%0d got=%b want=%b", cyc, io.busy, exp_busy);
      m = {io.U, io.D, io.L, io.R};
      if (m != 4'b0) begin
        total_cnt++;
        if (q.size() == 0)
          $display("FAIL unexpected_pulse cyc=%0d got={U,D,L,R}=%b want=none", cyc, m);
        else begin
          e = q.pop_front();
          if (e.cyc == cyc && e.mask == m) pass_cnt++;
          else $display("FAIL pulse got cyc=%0d {U,D,L,R}=%b want cyc=%0d %b",
                        cyc, m, e.cyc, e.mask);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    io.key_n      = 4'hF;
    io.winResult  = 1'b0;
    io.loseResult = 1'b0;
    reset         = 1'b1;
    idle(3);
    total_cnt++;
    if ({io.L, io.R, io.U, io.D, io.busy} == 5'b0) pass_cnt++;
    else $display("FAIL reset_state got=%b want=00000", {io.L, io.R, io.U, io.D, io.busy});
    reset = 1'b0;
    idle(5);

    // Single L press of 20 cycles.
    io.key_n[KEY_L] = 1'b0; idle(20); io.key_n[KEY_L] = 1'b1; idle(30);

    // Bouncing R, never stable long enough.
    for (int i = 0; i < 10; i++) begin
      io.key_n[KEY_R] = 1'b0; idle(2); io.key_n[KEY_R] = 1'b1; idle(2);
    end
    idle(20);

    // Long U hold: first pulse plus auto-repeat train.
    io.key_n[KEY_U] = 1'b0; idle(150); io.key_n[KEY_U] = 1'b1; idle(30);

    // L and R together: dropped.
    io.key_n[1:0] = 2'b00; idle(10); io.key_n[1:0] = 2'b11; idle(30);

    // D held across a win, then a lose during hold-off.
    io.key_n[KEY_D] = 1'b0; idle(12);
    io.winResult = 1'b1; idle(1); io.winResult = 1'b0;
    idle(9);
    io.loseResult = 1'b1; idle(1); io.loseResult = 1'b0;
    idle(60);
    io.key_n[KEY_D] = 1'b1; idle(6);
    io.key_n[KEY_D] = 1'b0; idle(20);
    io.key_n[KEY_D] = 1'b1; idle(20);

    // Key held across a mid-run reset re-arms as a fresh press.
    io.key_n[KEY_L] = 1'b0; idle(10);
    #1 reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(20);
    io.key_n[KEY_L] = 1'b1; idle(20);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 39) == 0) io.key_n[k] = ~io.key_n[k];
      io.winResult  = ($urandom_range(0, 299) == 0);
      io.loseResult = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #1 reset = 1'b1;
        idle(2);
        reset = 1'b0;
      end
      idle(1);
    end
    io.key_n      = 4'hF;
    io.winResult  = 1'b0;
    io.loseResult = 1'b0;
    idle(100);

    total_cnt++;
    if (q.size() == 0) pass_cnt++;
    else $display("FAIL missing_pulses got_outstanding=%0d want=0 first_cyc=%0d",
                  q.size(), q[0].cyc);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
Upstream input stage for the frog movement logic. Conditions four raw active-low push-buttons and emits clean single-cycle move pulses L, R, U, D: 2-flop synchronisation, per-key debounce, press-and-hold auto-repeat, and mutual exclusion. The L/R pulses drive the horizontal shifter; the U/D pulses drive the row tracker. After a round ends (win or lose), moves are blocked for a fixed hold-off, and any held key must be released before it can move the frog again.

Parameters:
DEBOUNCE_CYCLES, 4, cycles the synchronised key must stay stable before a press or release is accepted (board build overrides).
REPEAT_DELAY, 64, cycles from the first pulse to the first auto-repeat pulse.
REPEAT_RATE, 16, cycles between later auto-repeat pulses.
HOLDOFF, 32, cycles moves are blocked after winResult/loseResult.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_n  input  4  raw buttons, active-low; [0]=R, [1]=L, [2]=D, [3]=U
winResult  input  1  round-won pulse
loseResult  input  1  round-lost pulse
L  output  1  move-left pulse, one cycle
R  output  1  move-right pulse, one cycle
U  output  1  move-up pulse, one cycle
D  output  1  move-down pulse, one cycle
busy  output  1  high while hold-off is active

Behaviour:
- Interface: single clock `clk`. `reset` is asynchronous and active-high.
- Reset values: L=R=U=D=0, busy=0, sync flops=0 (key released), every conditioner in IDLE with cnt=0, hold-off counter=0.
- Sync stage: two flops per key, inverted, giving btn_s (1 = pressed).
- Per-key conditioner FSM, with counter cnt and registered pulse output p:
  - IDLE: btn_s=1 -> ARM, cnt=0.
  - ARM: btn_s=0 -> IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, p=1; else cnt++.
  - HELD: btn_s=0 -> REL, cnt=0. Otherwise, if cnt==REPEAT_DELAY-1 -> RPT, cnt=0, p=1; else cnt++.
  - RPT: btn_s=0 -> REL, cnt=0. Otherwise, if cnt==REPEAT_RATE-1 -> cnt=0, p=1; else cnt++.
  - REL: btn_s=1 -> cnt=0 and stay in REL (bounce). Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt++.
  - p is 0 in every cycle not listed above.
- Latency: if edge N is the first edge to sample a key pressed, that key's first p is high in the cycle after edge N+DEBOUNCE_CYCLES+2.
- Counter width: $clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE. No wrap is reachable.
- Mutual exclusion: outputs are registered. If two or more p are high in the same cycle, all four outputs are 0 that cycle (the event is dropped, no priority). Otherwise the single p is copied to its output. Output latency is one cycle after p.
- Hold-off:
  - winResult|loseResult sampled high -> hold-off counter loads HOLDOFF and every conditioner is forced to REL with cnt=0.
  - busy = (counter != 0). The counter decrements each cycle until it reaches 0.
  - Outputs are forced to 0 while busy, and in the same cycle as a win/lose sample.
  - A repeated win/lose during hold-off reloads the counter to HOLDOFF.
- Held keys across a round boundary: a key held through a round end stays in REL and emits nothing. It must be released for DEBOUNCE_CYCLES cycles and then pressed again.
- Reset mid-operation: asynchronously returns everything to its reset values. A key still held after reset deasserts is treated as a fresh press.

Decomposition:
- Package frogger_pkg holds:
  - typedef enum btn_state_t {IDLE, ARM, HELD, RPT, REL};
  - key index constants KEY_R=0, KEY_L=1, KEY_D=2, KEY_U=3.
- Sub-module key_conditioner contains the sync, FSM and counter for one key, plus force_rel and p ports. It is instantiated 4 times.
- Top level holds the exclusion logic, output registers and hold-off counter.

Test Plan:
1. Assert reset mid-run, then release -> all outputs 0, busy=0. A key held across reset gives a pulse DEBOUNCE_CYCLES+2 edges after release.
2. key_n[1] low from edge N, released after 20 cycles (defaults) -> exactly one L pulse, in the cycle after edge N+7 (6 to p, +1 output register). No R/U/D activity.
3. key_n[0] toggles every 2 cycles for 20 cycles, then stays high -> no R pulse.
4. Hold key_n[3] for 150 cycles -> U pulses at t0, t0+64, t0+80, t0+96, t0+112, t0+128, t0+144. Release -> no further pulses.
5. key_n[0] and key_n[1] driven low on the same edge and held 10 cycles -> L=R=0 throughout.
6. Hold key_n[2] past its first D pulse, pulse winResult for one cycle -> busy high for 32 cycles, D=0. D stays 0 after busy falls until the key is released ≥4 cycles and pressed again. A second loseResult at busy cycle 10 extends busy to 32 cycles from that point.
